seri2para: RTL and testbench

- Serial-to-parallel packer. It sits upstream of the parallel-to-serial unpacker and of the wide PE-array input port.
- Collects OUT_NUM consecutive IN_WIDTH-bit beats from a valid/ready stream into one IN_WIDTH*OUT_NUM-bit word.
- Lane order is lane 0 = first beat = bits [IN_WIDTH-1:0]. This is exactly the order in which the downstream unpacker re-emits lanes.
- Optional last-beat flush emits short, zero-padded groups at tile boundaries.

---
 rtl/acc_pkg.sv | 32 +++
 rtl/seri2para.sv | 131 +++++++++++++
 tb/tb_seri2para.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared accumulator-path definitions for the packer and its downstream unpacker.
// Latency: n/a (constants, types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   ACC_IN_WIDTH / ACC_OUT_NUM : default beat width and lane count, shared with the unpacker
//   pack_state_e               : two-state packer control (accumulating / holding a word)
//   lane_lsb()                 : lane index -> bit offset of that lane in a packed word
//   cnt_width()                : width of a counter that must hold 0..n
package acc_pkg;

  localparam int ACC_IN_WIDTH = 32;
  localparam int ACC_OUT_NUM  = 8;

  // S_ACC: collecting beats, no packed word pending.
  // S_HOLD: a packed word is presented on the output.
  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } pack_state_e;

  // Lane 0 occupies the least significant bits of the packed word.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Enough bits to represent every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seri2para.sv
// Serial-to-parallel packer: gathers OUT_NUM beats of IN_WIDTH bits into one wide word.
// Latency: completing beat accepted in cycle t -> out_valid in cycle t+1; 1 beat/cycle sustained.
// Backpressure: in_ready = !out_valid | out_ready; a stalled word blocks input, nothing is dropped.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in     : serial beat stream (lane 0 = first beat)
//   in_last                  : group terminator, present only with SERI2PARA_LAST_EN
//   out_valid/out_ready/out  : packed word stream, lane i at [IN_WIDTH*(i+1)-1 : IN_WIDTH*i]
//   out_cnt                  : number of valid lanes in out (1..OUT_NUM)
//   out_last                 : word was closed by in_last (constant 0 without SERI2PARA_LAST_EN)
//
// Build option: define SERI2PARA_LAST_EN to enable short-group flush with zero padding.
module seri2para
  import acc_pkg::*;
#(
  parameter int OUT_NUM   = ACC_OUT_NUM,
  parameter int IN_WIDTH  = ACC_IN_WIDTH,
  parameter int CNT_WIDTH = cnt_width(OUT_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in,
`ifdef SERI2PARA_LAST_EN
  input  logic                         in_last,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_WIDTH*OUT_NUM-1:0]  out,
  output logic [CNT_WIDTH-1:0]         out_cnt,
  output logic                         out_last
);

  localparam int                   WORD_W  = IN_WIDTH * OUT_NUM;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(OUT_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  pack_state_e            state_q;
  logic [CNT_WIDTH-1:0]   cnt;       // next lane to be written, 0..OUT_NUM-1
  logic [WORD_W-1:0]      acc_q;     // lanes collected so far; lanes >= cnt are always zero
  logic [WORD_W-1:0]      acc_d;
  logic [WORD_W-1:0]      word_d;    // word to publish if the current beat completes the group
  logic [OUT_NUM-1:0]     lane_we;

  logic in_fire;
  logic out_fire;
  logic last_beat;
  logic complete;

  assign out_valid = (state_q == S_HOLD);
  // A held word that is not being taken blocks input; that is the only stall source.
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

`ifdef SERI2PARA_LAST_EN
  assign last_beat = in_last;
`else
  assign last_beat = 1'b0;
`endif

  assign complete = in_fire && ((cnt == CNT_MAX) || last_beat);

  // Lane write-enable decode plus the word that a completing beat would produce.
  // Lanes below cnt come from the accumulator, lane cnt takes the incoming beat and
  // everything above is explicitly zero, so a short flushed group is zero-padded.
  always_comb begin
    acc_d   = acc_q;
    word_d  = '0;
    lane_we = '0;
    for (int i = 0; i < OUT_NUM; i++) begin
      lane_we[i] = in_fire && (cnt == CNT_WIDTH'(i));
      if (lane_we[i]) begin
        acc_d[lane_lsb(i, IN_WIDTH) +: IN_WIDTH] = in;
      end
      if (cnt > CNT_WIDTH'(i)) begin
        word_d[lane_lsb(i, IN_WIDTH) +: IN_WIDTH] = acc_q[lane_lsb(i, IN_WIDTH) +: IN_WIDTH];
      end else if (lane_we[i]) begin
        word_d[lane_lsb(i, IN_WIDTH) +: IN_WIDTH] = in;
      end
    end
  end

  // Control, lane counter, accumulator and output register.
  // A completing beat always wins: it reloads the output register even when the
  // previous word leaves in the same cycle, so back-to-back words have no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ACC;
      cnt      <= '0;
      acc_q    <= '0;
      out      <= '0;
      out_cnt  <= '0;
      out_last <= 1'b0;
    end else begin
      if (complete) begin
        out      <= word_d;
        out_cnt  <= cnt + CNT_ONE;
        out_last <= last_beat;
        cnt      <= '0;
        acc_q    <= '0;
        state_q  <= S_HOLD;
      end else begin
        if (in_fire) begin
          acc_q <= acc_d;
          cnt   <= cnt + CNT_ONE;
        end
        // Word taken with nothing new to show; out/out_cnt/out_last keep stale values.
        if (out_fire) begin
          state_q <= S_ACC;
        end
      end
    end
  end

  // Counter stays within a single group.
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_MAX);

  // A stalled word is neither replaced nor altered.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(out_cnt) && $stable(out_last)));

`ifndef SERI2PARA_LAST_EN
  // Without flush support every published word is full.
  a_full_only: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (out_cnt == CNT_WIDTH'(OUT_NUM)));
`endif

endmodule

// File: tb/tb_seri2para.sv
module tb_seri2para;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
`ifdef SERI2PARA_LAST_EN
  logic           in_last_r;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [W*N-1:0] out_data;
  logic [CW-1:0]  out_cnt;
  logic           out_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [W*N-1:0] held_word;

  always #5 clk = ~clk;

  seri2para #(.OUT_NUM(N), .IN_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
`ifdef SERI2PARA_LAST_EN
    .in_last   (in_last_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data),
    .out_cnt   (out_cnt),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected packed word: lanes 0..n-1 hold base, base+1, ...; remaining lanes zero.
  function automatic logic [255:0] seq_word(input logic [31:0] base, input int n);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (i < n) w[i*W +: W] = base + 32'(i);
    end
    return w;
  endfunction

  // Present one beat (called at posedge+1), confirm it is acceptable, let it clock in.
  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check("beat_in_ready", {255'd0, in_ready}, 256'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

`ifdef SERI2PARA_LAST_EN
  task automatic beat_l(input logic [31:0] d, input logic l);
    in_last_r = l;
    beat(d);
    in_last_r = 1'b0;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef SERI2PARA_LAST_EN
    in_last_r = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", {255'd0, out_valid}, 256'd0);
    check("rst_out",       out_data,            256'd0);
    check("rst_out_cnt",   {252'd0, out_cnt},   256'd0);
    check("rst_out_last",  {255'd0, out_last},  256'd0);
    check("rst_in_ready",  {255'd0, in_ready},  256'd1);

    // Full packing, beats 1..8 back-to-back
    for (int i = 1; i <= 8; i++) begin
      beat(32'(i));
      if (i == 7) check("full_no_early_valid", {255'd0, out_valid}, 256'd0);
    end
    check("full_out_valid", {255'd0, out_valid}, 256'd1);
    check("full_out", out_data,
          256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    check("full_out_cnt",  {252'd0, out_cnt},  256'd8);
    check("full_out_last", {255'd0, out_last}, 256'd0);

    // Backpressure: word held for 5 cycles while beat 0x9 waits
    held_word = seq_word(32'h1, 8);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h9;
    #1;
    check("bp_in_ready_low", {255'd0, in_ready}, 256'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid",    {255'd0, out_valid}, 256'd1);
      check("bp_hold_out",      out_data,            held_word);
      check("bp_hold_in_ready", {255'd0, in_ready},  256'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {255'd0, in_ready}, 256'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_drained", {255'd0, out_valid}, 256'd0);
    for (int i = 10; i <= 16; i++) beat(32'(i));
    check("bp_word2_valid", {255'd0, out_valid}, 256'd1);
    check("bp_word2_out",   out_data,            seq_word(32'h9, 8));
    check("bp_word2_cnt",   {252'd0, out_cnt},   256'd8);

    // Back-to-back groups, 16 beats; first beat enters as the previous word drains
    for (int i = 0; i < 16; i++) begin
      beat(32'h41 + 32'(i));
      if (i == 7) begin
        check("b2b_word1_valid", {255'd0, out_valid}, 256'd1);
        check("b2b_word1_out",   out_data,            seq_word(32'h41, 8));
      end
      if (i == 8) check("b2b_word1_gone", {255'd0, out_valid}, 256'd0);
    end
    check("b2b_word2_valid", {255'd0, out_valid}, 256'd1);
    check("b2b_word2_out",   out_data,            seq_word(32'h49, 8));
    check("b2b_word2_cnt",   {252'd0, out_cnt},   256'd8);
    @(posedge clk);
    #1;
    check("b2b_idle", {255'd0, out_valid}, 256'd0);

    // Mid-operation reset discards a partial group
    for (int i = 0; i < 5; i++) beat(32'h31 + 32'(i));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_out_valid", {255'd0, out_valid}, 256'd0);
    check("mrst_out",       out_data,            256'd0);
    check("mrst_out_cnt",   {252'd0, out_cnt},   256'd0);
    for (int i = 0; i < 8; i++) begin
      beat(32'h21 + 32'(i));
      if (i == 6) check("mrst_no_early_valid", {255'd0, out_valid}, 256'd0);
    end
    check("mrst_word_valid", {255'd0, out_valid}, 256'd1);
    check("mrst_word_out",   out_data,            seq_word(32'h21, 8));
    @(posedge clk);
    #1;
    check("mrst_drained", {255'd0, out_valid}, 256'd0);

`ifdef SERI2PARA_LAST_EN
    // Short flush: 3 beats, zero padded
    beat_l(32'hA, 1'b0);
    beat_l(32'hB, 1'b0);
    beat_l(32'hC, 1'b1);
    check("flush_valid", {255'd0, out_valid}, 256'd1);
    check("flush_out",   out_data,            seq_word(32'hA, 3));
    check("flush_cnt",   {252'd0, out_cnt},   256'd3);
    check("flush_last",  {255'd0, out_last},  256'd1);
    // Single-beat group completes while the previous word leaves: no bubble
    beat_l(32'hD, 1'b1);
    check("reload_valid", {255'd0, out_valid}, 256'd1);
    check("reload_out",   out_data,            seq_word(32'hD, 1));
    check("reload_cnt",   {252'd0, out_cnt},   256'd1);
    check("reload_last",  {255'd0, out_last},  256'd1);
    // in_last on the eighth beat gives a full word flagged last
    for (int i = 0; i < 8; i++) beat_l(32'h71 + 32'(i), (i == 7));
    check("lastfull_out",  out_data,           seq_word(32'h71, 8));
    check("lastfull_cnt",  {252'd0, out_cnt},  256'd8);
    check("lastfull_last", {255'd0, out_last}, 256'd1);
    @(posedge clk);
    #1;
    check("lastfull_drained", {255'd0, out_valid}, 256'd0);
`endif

    // A short group on its own never produces a word without flush
    for (int i = 0; i < 3; i++) beat(32'h61 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("partial_no_valid", {255'd0, out_valid}, 256'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
